// File: rtl/vc_test_multi_source_pkg.sv
// Shared channel FSM state, LFSR tap mask and width helpers for the multi-channel test source.
package vc_test_multi_source_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_DELAY,
        ST_SEND,
        ST_FIN
    } chan_state_t;

    // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/vc_test_multi_source_if.sv
// Load port, per-channel val/rdy/msg streams and completion flags of the multi-channel test source.
interface vc_test_multi_source_if
    import vc_test_multi_source_pkg::*;
#(
    parameter int unsigned p_msg_nbits = 32,
    parameter int unsigned p_num_chans = 2
);
    localparam int unsigned CHW = idx_w(p_num_chans);

    logic                               load_val;
    logic [CHW-1:0]                     load_chan;
    logic [p_msg_nbits-1:0]             load_msg;
    logic                               start;
    logic [p_num_chans-1:0]             val;
    logic [p_num_chans-1:0]             rdy;
    logic [p_num_chans*p_msg_nbits-1:0] msg;
    logic [p_num_chans-1:0]             done;
    logic                               all_done;

    modport master (
        input  load_val, load_chan, load_msg, start, rdy,
        output val, msg, done, all_done
    );

    modport slave (
        output load_val, load_chan, load_msg, start, rdy,
        input  val, msg, done, all_done
    );

endinterface

// File: rtl/vc_test_multi_source_chan.sv
// One source channel: replays loaded messages, registered outputs; msg held until val && rdy.
// Random inter-message delay only when VC_TEST_MULTI_SOURCE_RAND_DELAY_EN is defined.
module vc_test_multi_source_chan
    import vc_test_multi_source_pkg::*;
#(
    parameter int unsigned p_msg_nbits = 32,
    parameter int unsigned p_num_msgs  = 1024,
    parameter int unsigned p_max_delay = 3,
    parameter logic [15:0] p_seed      = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_en,
    input  logic [p_msg_nbits-1:0] load_msg,
    input  logic                   start,
    input  logic                   rdy,
    output logic                   val,
    output logic [p_msg_nbits-1:0] msg,
    output logic                   done
);
    localparam int unsigned   CW      = idx_w(p_num_msgs + 1);
    localparam int unsigned   AW      = idx_w(p_num_msgs);
    localparam int unsigned   DW      = idx_w(p_max_delay + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(p_num_msgs);

    chan_state_t            state;
    logic [p_msg_nbits-1:0] mem [p_num_msgs];
    logic [CW-1:0]          count;
    logic [CW-1:0]          index;
    logic [CW-1:0]          index_nxt;
    logic [CW-1:0]          rd_idx;
    logic [DW-1:0]          dly_cnt;
    logic [DW-1:0]          dly_draw;
    logic [p_msg_nbits-1:0] mem_rd;
    logic                   load_ok;
    logic                   enter_delay;
    logic                   enter_fin;

    assign index_nxt = index + 1'b1;
    // A message entering SEND straight out of SEND is the one after the current index
    assign rd_idx    = (state == ST_SEND) ? index_nxt : index;
    assign mem_rd    = mem[rd_idx[AW-1:0]];
    assign load_ok   = (state == ST_LOAD) && load_en && (count != MAX_CNT);

`ifdef VC_TEST_MULTI_SOURCE_RAND_DELAY_EN
    localparam logic [15:0] SEED = (p_seed == 16'h0) ? 16'h1 : p_seed;
    localparam logic [15:0] MODV = 16'(p_max_delay + 1);

    logic [15:0] lfsr;
    logic [15:0] lfsr_mod;

    assign lfsr_mod = lfsr % MODV;
    assign dly_draw = lfsr_mod[DW-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr <= SEED;
        end else if (enter_delay) begin
            lfsr <= lfsr_step(lfsr);
        end
    end
`else
    logic [15:0] unused_seed;
    assign unused_seed = p_seed;
    assign dly_draw    = '0;
`endif

    always_comb begin
        enter_delay = 1'b0;
        enter_fin   = 1'b0;
        case (state)
            ST_LOAD: if (start) begin
                enter_delay = (count != '0);
                enter_fin   = (count == '0);
            end
            ST_SEND: if (rdy) begin
                enter_delay = (index_nxt != count);
                enter_fin   = (index_nxt == count);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (load_ok && reset) begin
            mem[count[AW-1:0]] <= load_msg;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_LOAD;
            count   <= '0;
            index   <= '0;
            dly_cnt <= '0;
            val     <= 1'b0;
            msg     <= '0;
            done    <= 1'b0;
        end else begin
            if (load_ok) begin
                count <= count + 1'b1;
            end
            if (state == ST_SEND && rdy) begin
                index <= index_nxt;
            end
            if (enter_fin) begin
                state <= ST_FIN;
                val   <= 1'b0;
                msg   <= '0;
                done  <= 1'b1;
            end else if (enter_delay && dly_draw != '0) begin
                state   <= ST_DELAY;
                dly_cnt <= dly_draw;
                val     <= 1'b0;
                msg     <= '0;
            end else if (enter_delay || (state == ST_DELAY && dly_cnt == DW'(1))) begin
                // a zero draw skips DELAY entirely so back-to-back sends stay gapless
                state <= ST_SEND;
                val   <= 1'b1;
                msg   <= mem_rd;
            end else if (state == ST_DELAY) begin
                dly_cnt <= dly_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/vc_test_multi_source.sv
// Multi-channel test source: loads per-channel message lists, then replays them on independent val/rdy streams.
// Outputs registered in each channel; rdy of one channel never stalls another. Option: VC_TEST_MULTI_SOURCE_RAND_DELAY_EN.
module vc_test_multi_source
    import vc_test_multi_source_pkg::*;
#(
    parameter int unsigned p_msg_nbits = 32,
    parameter int unsigned p_num_msgs  = 1024,
    parameter int unsigned p_num_chans = 2,
    parameter int unsigned p_max_delay = 3,
    parameter logic [15:0] p_seed      = 16'hACE1
) (
    input logic                   clk,
    input logic                   reset,
    vc_test_multi_source_if.master src
);
    localparam int unsigned CHW = idx_w(p_num_chans);

    logic [p_num_chans-1:0]             val_w;
    logic [p_num_chans-1:0]             done_w;
    logic [p_num_chans*p_msg_nbits-1:0] msg_w;

    for (genvar i = 0; i < p_num_chans; i++) begin : g_chan
        logic load_en;
        // out-of-range load_chan matches no channel and is dropped
        assign load_en = src.load_val && (src.load_chan == CHW'(i));

        vc_test_multi_source_chan #(
            .p_msg_nbits (p_msg_nbits),
            .p_num_msgs  (p_num_msgs),
            .p_max_delay (p_max_delay),
            .p_seed      (p_seed ^ 16'(i))
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .load_en  (load_en),
            .load_msg (src.load_msg),
            .start    (src.start),
            .rdy      (src.rdy[i]),
            .val      (val_w[i]),
            .msg      (msg_w[i*p_msg_nbits +: p_msg_nbits]),
            .done     (done_w[i])
        );
    end

    assign src.val      = val_w;
    assign src.msg      = msg_w;
    assign src.done     = done_w;
    assign src.all_done = &done_w;

    always @(posedge clk) begin
        if (reset) begin
            assert (!$isunknown(src.val));
            assert (!$isunknown(src.rdy));
        end
    end

endmodule

// File: tb/tb_vc_test_multi_source.sv
// Randomized bench for vc_test_multi_source against a queue-based model of the load/replay rules.
module tb_vc_test_multi_source;
    import vc_test_multi_source_pkg::*;

    localparam int unsigned MW   = 32;
    localparam int unsigned NM   = 8;
    localparam int unsigned NC   = 3;
    localparam int unsigned MAXD = 3;
    localparam int unsigned CHW  = idx_w(NC);
`ifdef VC_TEST_MULTI_SOURCE_RAND_DELAY_EN
    localparam int unsigned LIM = MAXD;
`else
    localparam int unsigned LIM = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vc_test_multi_source_if #(.p_msg_nbits(MW), .p_num_chans(NC)) ifc ();

    vc_test_multi_source #(
        .p_msg_nbits (MW),
        .p_num_msgs  (NM),
        .p_num_chans (NC),
        .p_max_delay (MAXD),
        .p_seed      (16'hACE1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .src   (ifc)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit rdy_rand = 1'b0;

    // reference model: what each channel still owes, in order
    logic [MW-1:0] q [NC][$];
    int            cnt [NC];
    int            xfer [NC];
    int            gap [NC];
    bit            waiting [NC];
    bit [NC-1:0]   fin = '0;
    bit            in_load = 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            q[c].delete();
            cnt[c]     = 0;
            xfer[c]    = 0;
            gap[c]     = 0;
            waiting[c] = 1'b0;
        end
        fin     = '0;
        in_load = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        logic          v;
        logic [MW-1:0] m;
        int            lc;
        for (int c = 0; c < NC; c++) begin
            v = ifc.val[c];
            m = ifc.msg[c*MW +: MW];
            check("done", 64'(ifc.done[c]), 64'(fin[c]));
            if (in_load || fin[c] || q[c].size() == 0) check("val_idle", 64'(v), 0);
            else if (v) check("msg", 64'(m), 64'(q[c][0]));
            if (!v) check("msg_zero", 64'(m), 0);
            if (waiting[c]) begin
                if (v) begin
                    check("gap", 64'(gap[c] <= int'(LIM)), 1);
                    waiting[c] = 1'b0;
                end else begin
                    gap[c]++;
                end
            end
        end
        check("all_done", 64'(ifc.all_done), 64'(&fin));
        if (!reset) begin
            model_reset();
        end else begin
            for (int c = 0; c < NC; c++) begin
                if (!in_load && !fin[c] && ifc.val[c] && ifc.rdy[c] && q[c].size() > 0) begin
                    void'(q[c].pop_front());
                    xfer[c]++;
                    if (q[c].size() == 0) fin[c] = 1'b1;
                    else begin
                        waiting[c] = 1'b1;
                        gap[c]     = 0;
                    end
                end
            end
            lc = int'(ifc.load_chan);
            if (in_load && ifc.load_val && lc < NC && cnt[lc] < NM) begin
                q[lc].push_back(ifc.load_msg);
                cnt[lc]++;
            end
            if (in_load && ifc.start) begin
                in_load = 1'b0;
                for (int c = 0; c < NC; c++) begin
                    if (cnt[c] == 0) fin[c] = 1'b1;
                    else begin
                        waiting[c] = 1'b1;
                        gap[c]     = 0;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rdy_rand) ifc.rdy = NC'($urandom);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) cyc();
        reset = 1'b1;
    endtask

    task automatic load(input int ch, input logic [MW-1:0] m);
        ifc.load_val  = 1'b1;
        ifc.load_chan = CHW'(ch);
        ifc.load_msg  = m;
        cyc();
        ifc.load_val  = 1'b0;
    endtask

    task automatic pulse_start();
        ifc.start = 1'b1;
        cyc();
        ifc.start = 1'b0;
    endtask

    task automatic wait_all_done(input int budget, input string tag);
        for (int i = 0; i < budget && !ifc.all_done; i++) cyc();
        check(tag, 64'(ifc.all_done), 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.load_val  = 1'b0;
        ifc.load_chan = '0;
        ifc.load_msg  = '0;
        ifc.start     = 1'b0;
        ifc.rdy       = '1;

        do_reset(3);
        check("rst_val", 64'(ifc.val), 0);
        check("rst_msg", 64'(ifc.msg), 0);
        check("rst_done", 64'(ifc.done), 0);
        check("rst_all_done", 64'(ifc.all_done), 0);

        // basic replay, ch2 left empty
        load(0, 32'h11); load(0, 32'h22); load(0, 32'h33); load(1, 32'hA0);
        pulse_start();
        check("empty_done", 64'(ifc.done[2]), 1);
        wait_all_done(100, "basic_all_done");
        check("basic_xfer0", 64'(xfer[0]), 3);
        check("basic_xfer1", 64'(xfer[1]), 1);
        check("basic_xfer2", 64'(xfer[2]), 0);

        // backpressure holds val/msg
        do_reset(2);
        load(0, 32'h11);
        ifc.rdy = 3'b110;
        pulse_start();
        for (int i = 0; i < 10 && !ifc.val[0]; i++) cyc();
        for (int i = 0; i < 5; i++) begin
            check("bp_val", 64'(ifc.val[0]), 1);
            check("bp_msg", 64'(ifc.msg[MW-1:0]), 64'h11);
            cyc();
        end
        ifc.rdy = '1;
        wait_all_done(50, "bp_all_done");
        check("bp_xfer0", 64'(xfer[0]), 1);

        // overflow, out-of-range channel, load after start
        do_reset(2);
        for (int i = 0; i < NM + 2; i++) load(0, 32'h100 + i);
        load(3, 32'hDEAD);
        pulse_start();
        load(1, 32'hBEEF);
        wait_all_done(200, "ovf_all_done");
        check("ovf_xfer0", 64'(xfer[0]), NM);
        check("ovf_xfer1", 64'(xfer[1]), 0);

        // reset mid-transfer, then reload
        do_reset(2);
        load(0, 32'h1); load(0, 32'h2); load(0, 32'h3);
        pulse_start();
        for (int i = 0; i < 50 && xfer[0] < 2; i++) cyc();
        check("mid_xfer", 64'(xfer[0]), 2);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        check("mid_rst_val", 64'(ifc.val[0]), 0);
        check("mid_rst_done", 64'(ifc.done[0]), 0);
        load(0, 32'h77); load(0, 32'h88);
        pulse_start();
        wait_all_done(100, "reload_all_done");
        check("reload_xfer0", 64'(xfer[0]), 2);

        // randomized rounds
        rdy_rand = 1'b1;
        for (int r = 0; r < 40; r++) begin
            do_reset(2);
            for (int k = 0; k < $urandom_range(0, NC*NM + 4); k++)
                load($urandom_range(0, 3), $urandom);
            pulse_start();
            if ($urandom_range(0, 3) == 0) begin
                load($urandom_range(0, 2), $urandom);
                pulse_start();
            end
            if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1, 15)) cyc();
            else wait_all_done(600, "rand_all_done");
        end
        rdy_rand = 1'b0;
        ifc.rdy  = '1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vc_test_multi_source.md
VC_TEST_MULTI_SOURCE -- requirements
Module: vc_test_multi_source

Interface
REQ-001 Parameter p_msg_nbits, default 32, message width in bits.
REQ-002 Parameter p_num_msgs, default 1024, per-channel message memory depth.
REQ-003 Parameter p_num_chans, default 2, number of independent source channels.
REQ-004 Parameter p_max_delay, default 3, max random inter-message delay in cycles.
REQ-005 Parameter p_seed, default 16'hACE1, base LFSR seed.
REQ-006 clk  input  1  clock.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 load_val  input  1  append load_msg to channel load_chan.
REQ-009 load_chan  input  max(1,$clog2(p_num_chans))  target channel of load.
REQ-010 load_msg  input  p_msg_nbits  message to append.
REQ-011 start  input  1  one-cycle pulse; all channels begin sending.
REQ-012 val  output  p_num_chans  per-channel valid.
REQ-013 rdy  input  p_num_chans  per-channel ready.
REQ-014 msg  output  p_num_chans*p_msg_nbits  flattened messages; channel i at bits [i*p_msg_nbits +: p_msg_nbits].
REQ-015 done  output  p_num_chans  channel has issued all loaded messages.
REQ-016 all_done  output  1  AND of done.

Function
REQ-017 Each channel SHALL hold a message memory, a count (width $clog2(p_num_msgs+1)), a read index, a delay counter and a 4-state FSM: LOAD, DELAY, SEND, FIN.
REQ-018 In LOAD, load_val SHALL write load_msg at m[count] of load_chan and increment count in the same cycle.
REQ-019 A load to a channel with count == p_num_msgs, to load_chan >= p_num_chans, or outside LOAD SHALL be ignored.
REQ-020 start in LOAD SHALL move every channel to DELAY (count > 0) or FIN (count == 0) on the next edge; start in any other state SHALL be ignored.
REQ-021 On entering DELAY the channel SHALL draw d = LFSR mod (p_max_delay+1) and hold val low for exactly d cycles, then enter SEND; d == 0 SHALL enter SEND the next cycle.
REQ-022 In SEND val SHALL be 1 and msg SHALL equal m[index], stable until val && rdy.
REQ-023 On val && rdy the index SHALL increment; next state SHALL be FIN if index+1 == count, else DELAY.
REQ-024 In FIN val SHALL be 0 and done SHALL be 1; done SHALL be 0 in all other states.
REQ-025 msg SHALL be 0 whenever val is 0.
REQ-026 Channels SHALL advance independently; rdy of one channel SHALL not affect another.
REQ-027 Each channel's LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, seeded p_seed ^ i, never 0, advancing once per DELAY entry.

Reset
REQ-028 While reset == 0 at a clk edge: all FSMs SHALL enter LOAD; count, index, delay counter SHALL be 0; LFSRs SHALL reseed.
REQ-029 Reset outputs: val = 0, msg = 0, done = 0, all_done = 0.
REQ-030 Reset mid-transfer SHALL discard loaded messages (count = 0); memory contents need not be cleared.

Configuration
REQ-031 Macro VC_TEST_MULTI_SOURCE_RAND_DELAY_EN defined: random delay per REQ-021/REQ-027.
REQ-032 Macro undefined: LFSRs SHALL not be built, d SHALL always be 0, p_max_delay and p_seed SHALL be ignored.

Structure
REQ-033 Package vc_test_multi_source_pkg SHALL hold the FSM state typedef and LFSR tap constant.
REQ-034 Sub-module vc_test_multi_source_chan SHALL implement one channel; the top SHALL instantiate p_num_chans copies and decode load_chan.
REQ-035 Per-cycle assertions (outside reset): val, rdy not X; line trace per channel via the existing val/rdy trace helper.

Verification
REQ-036 Macro off, 2 chans, load ch0 {0x11,0x22,0x33}, ch1 {0xA0}, start, rdy=11 -> ch0 val high 3 consecutive cycles 0x11,0x22,0x33; ch1 0xA0 once; all_done 1 cycle after last transfer.
REQ-037 rdy[0] low 5 cycles during SEND -> val[0]=1 and msg 0x11 held 5 cycles, then accepted.
REQ-038 Macro on, p_max_delay=3, 100 msgs, rdy=1 -> every gap between transfers in 0..3 cycles, all 100 in order.
REQ-039 Start with ch1 count 0 -> done[1]=1 one cycle after start, val[1] never 1.
REQ-040 p_num_msgs=4, load 5 msgs to ch0 -> count stays 4, 5th dropped; load after start ignored.
REQ-041 reset=0 after 2 of 3 transfers -> next cycle val=0, done=0; re-load and start sends new data from index 0.
